// File: rtl/alu_rs_pkg.sv
// Shared types for the ALU reservation station: entry layout, issue FSM states, ALU function codes.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package alu_rs_pkg;

    localparam int RS_ROB_IX  = 2;   // rob index is [RS_ROB_IX:0]
    localparam int RS_ENTRIES = 4;   // station depth

    // AluFunc codes carried through the station untouched
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLL  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_SLT  = 4'h8;
    localparam logic [3:0] ALU_SLTU = 4'h9;

    typedef logic [RS_ROB_IX:0] rob_ix_t;

    typedef struct packed {
        logic        valid;
        logic [3:0]  func;
        rob_ix_t     rob_ix;
        logic [31:0] v1;
        rob_ix_t     q1;
        logic        p1;
        logic [31:0] v2;
        rob_ix_t     q2;
        logic        p2;
    } rs_entry_t;

    typedef enum logic [1:0] {
        RS_IDLE  = 2'd0,
        RS_ISSUE = 2'd1,
        RS_BUSY  = 2'd2
    } rs_state_t;

    // True when a pending operand waiting on tag q is satisfied by this CDB broadcast.
    function automatic logic cdb_hit(input logic pend, input logic cdb_vld,
                                     input rob_ix_t cdb_tag, input rob_ix_t q);
        return pend && cdb_vld && (cdb_tag == q);
    endfunction

endpackage

// File: rtl/alu_rs_prio_enc.sv
// Priority encoder: index of the lowest set request bit, plus an any-set flag.
// Latency: purely combinational.
// Backpressure: n/a.
// Ports: req_i request vector; idx_o lowest set index (0 when none); any_o at least one bit set.
module prio_enc #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = W'(i);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/alu_rs.sv
// Reservation station for one ALU: buffers dispatched ops, snoops the CDB, issues the lowest-index ready op.
// Latency: dispatch with both operands ready in cycle D gives alu_valid_out in cycle D+2.
// Backpressure: disp_ready_out low when full; issue waits for alu_ready_in, operands held until the ALU is ready again.
// Ports: clk_in/rst_in/flush_in; disp_* dispatch request with operand values/tags/pending flags;
//        cdb_* result broadcast; alu_ready_in from the ALU; alu_* held operands plus 1-cycle valid pulse.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int ROB_IX  = RS_ROB_IX,   // entry tag width is fixed by rob_ix_t in the package
    parameter int ENTRIES = RS_ENTRIES
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              flush_in,
    input  logic              disp_valid_in,
    output logic              disp_ready_out,
    input  logic [3:0]        disp_func_in,
    input  logic [ROB_IX:0]   disp_rob_ix_in,
    input  logic [31:0]       disp_v1_in,
    input  logic [ROB_IX:0]   disp_q1_in,
    input  logic              disp_p1_in,
    input  logic [31:0]       disp_v2_in,
    input  logic [ROB_IX:0]   disp_q2_in,
    input  logic              disp_p2_in,
    input  logic              cdb_valid_in,
    input  logic [ROB_IX:0]   cdb_rob_ix_in,
    input  logic [31:0]       cdb_data_in,
    input  logic              alu_ready_in,
    output logic              alu_valid_out,
    output logic [31:0]       alu_rval1_out,
    output logic [31:0]       alu_rval2_out,
    output logic [3:0]        alu_func_out,
    output logic [ROB_IX:0]   alu_rob_ix_out
);

    localparam int IW = $clog2(ENTRIES);

    rs_entry_t        ent_q [ENTRIES];
    rs_entry_t        ent_d [ENTRIES];
    rs_entry_t        new_ent;
    rs_entry_t        sel_ent;
    rs_state_t        state_q, state_d;
    logic             alu_valid_q, alu_valid_d;
    logic [31:0]      rval1_q, rval1_d, rval2_q, rval2_d;
    logic [3:0]       func_q, func_d;
    logic [ROB_IX:0]  rob_q, rob_d;

    logic [ENTRIES-1:0] free_vec, rdy_vec;
    logic [IW-1:0]      free_idx, sel_idx;
    logic               free_any, sel_any;
    logic               disp_fire, issue_fire;

    // Both vectors come from registered state only, so a slot freed by this
    // cycle's issue is not offered for dispatch until the next cycle.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            free_vec[i] = !ent_q[i].valid;
            rdy_vec[i]  = ent_q[i].valid && !ent_q[i].p1 && !ent_q[i].p2;
        end
    end

    prio_enc #(.N(ENTRIES), .W(IW)) u_free_sel (
        .req_i (free_vec),
        .idx_o (free_idx),
        .any_o (free_any)
    );

    prio_enc #(.N(ENTRIES), .W(IW)) u_issue_sel (
        .req_i (rdy_vec),
        .idx_o (sel_idx),
        .any_o (sel_any)
    );

    assign disp_ready_out = free_any;
    assign disp_fire      = disp_valid_in && free_any;
    assign issue_fire     = (state_q == RS_IDLE) && sel_any && alu_ready_in;
    assign sel_ent        = ent_q[sel_idx];

    // Incoming entry, with a same-cycle CDB broadcast captured directly.
    always_comb begin
        new_ent        = '0;
        new_ent.valid  = 1'b1;
        new_ent.func   = disp_func_in;
        new_ent.rob_ix = disp_rob_ix_in;
        new_ent.q1     = disp_q1_in;
        new_ent.q2     = disp_q2_in;
        new_ent.v1     = disp_v1_in;
        new_ent.p1     = disp_p1_in;
        new_ent.v2     = disp_v2_in;
        new_ent.p2     = disp_p2_in;
        if (cdb_hit(disp_p1_in, cdb_valid_in, cdb_rob_ix_in, disp_q1_in)) begin
            new_ent.v1 = cdb_data_in;
            new_ent.p1 = 1'b0;
        end
        if (cdb_hit(disp_p2_in, cdb_valid_in, cdb_rob_ix_in, disp_q2_in)) begin
            new_ent.v2 = cdb_data_in;
            new_ent.p2 = 1'b0;
        end
    end

    // Wakeup, issue-free and dispatch-write act on disjoint conditions per slot:
    // the issued slot is already ready and the dispatch slot is currently invalid.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].valid && cdb_hit(ent_q[i].p1, cdb_valid_in, cdb_rob_ix_in, ent_q[i].q1)) begin
                ent_d[i].v1 = cdb_data_in;
                ent_d[i].p1 = 1'b0;
            end
            if (ent_q[i].valid && cdb_hit(ent_q[i].p2, cdb_valid_in, cdb_rob_ix_in, ent_q[i].q2)) begin
                ent_d[i].v2 = cdb_data_in;
                ent_d[i].p2 = 1'b0;
            end
            if (issue_fire && (sel_idx == IW'(i))) begin
                ent_d[i].valid = 1'b0;
            end
            if (disp_fire && (free_idx == IW'(i))) begin
                ent_d[i] = new_ent;
            end
        end
    end

    // Issue FSM; the hold registers load only on IDLE->ISSUE because the ALU
    // output is combinational from these values until it raises ready again.
    always_comb begin
        state_d     = state_q;
        alu_valid_d = 1'b0;
        rval1_d     = rval1_q;
        rval2_d     = rval2_q;
        func_d      = func_q;
        rob_d       = rob_q;
        case (state_q)
            RS_IDLE: begin
                if (issue_fire) begin
                    state_d     = RS_ISSUE;
                    alu_valid_d = 1'b1;
                    rval1_d     = sel_ent.v1;
                    rval2_d     = sel_ent.v2;
                    func_d      = sel_ent.func;
                    rob_d       = sel_ent.rob_ix;
                end
            end
            RS_ISSUE: state_d = RS_BUSY;
            RS_BUSY: begin
                if (alu_ready_in) begin
                    state_d = RS_IDLE;
                end
            end
            default: state_d = RS_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || flush_in) begin
            state_q     <= RS_IDLE;
            alu_valid_q <= 1'b0;
            rval1_q     <= '0;
            rval2_q     <= '0;
            func_q      <= '0;
            rob_q       <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            alu_valid_q <= alu_valid_d;
            rval1_q     <= rval1_d;
            rval2_q     <= rval2_d;
            func_q      <= func_d;
            rob_q       <= rob_d;
            for (int i = 0; i < ENTRIES; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    assign alu_valid_out  = alu_valid_q;
    assign alu_rval1_out  = rval1_q;
    assign alu_rval2_out  = rval2_q;
    assign alu_func_out   = func_q;
    assign alu_rob_ix_out = rob_q;

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: issue latency, CDB wakeup/bypass, full station, hold stability, flush.
// Latency: n/a.
// Backpressure: alu_ready_in driven directly by the stimulus.
module tb_alu_rs;
    import alu_rs_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, flush_in;
    logic        disp_valid_in, disp_ready_out;
    logic [3:0]  disp_func_in;
    logic [2:0]  disp_rob_ix_in, disp_q1_in, disp_q2_in;
    logic [31:0] disp_v1_in, disp_v2_in;
    logic        disp_p1_in, disp_p2_in;
    logic        cdb_valid_in;
    logic [2:0]  cdb_rob_ix_in;
    logic [31:0] cdb_data_in;
    logic        alu_ready_in, alu_valid_out;
    logic [31:0] alu_rval1_out, alu_rval2_out;
    logic [3:0]  alu_func_out;
    logic [2:0]  alu_rob_ix_out;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses;

    always #5 clk_in = ~clk_in;

    alu_rs #(.ROB_IX(2), .ENTRIES(4)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .flush_in       (flush_in),
        .disp_valid_in  (disp_valid_in),
        .disp_ready_out (disp_ready_out),
        .disp_func_in   (disp_func_in),
        .disp_rob_ix_in (disp_rob_ix_in),
        .disp_v1_in     (disp_v1_in),
        .disp_q1_in     (disp_q1_in),
        .disp_p1_in     (disp_p1_in),
        .disp_v2_in     (disp_v2_in),
        .disp_q2_in     (disp_q2_in),
        .disp_p2_in     (disp_p2_in),
        .cdb_valid_in   (cdb_valid_in),
        .cdb_rob_ix_in  (cdb_rob_ix_in),
        .cdb_data_in    (cdb_data_in),
        .alu_ready_in   (alu_ready_in),
        .alu_valid_out  (alu_valid_out),
        .alu_rval1_out  (alu_rval1_out),
        .alu_rval2_out  (alu_rval2_out),
        .alu_func_out   (alu_func_out),
        .alu_rob_ix_out (alu_rob_ix_out)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic disp(input logic [3:0] f, input logic [2:0] rob,
                        input logic [31:0] v1, input logic [2:0] q1, input logic p1,
                        input logic [31:0] v2, input logic [2:0] q2, input logic p2);
        disp_valid_in  = 1'b1;
        disp_func_in   = f;
        disp_rob_ix_in = rob;
        disp_v1_in     = v1;
        disp_q1_in     = q1;
        disp_p1_in     = p1;
        disp_v2_in     = v2;
        disp_q2_in     = q2;
        disp_p2_in     = p2;
    endtask

    task automatic cdb(input logic v, input logic [2:0] tag, input logic [31:0] d);
        cdb_valid_in  = v;
        cdb_rob_ix_in = tag;
        cdb_data_in   = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_in   = 1'b1;
        flush_in = 1'b0;
        disp(4'h0, 3'd0, 32'd0, 3'd0, 1'b0, 32'd0, 3'd0, 1'b0);
        disp_valid_in = 1'b0;
        cdb(1'b0, 3'd0, 32'd0);
        alu_ready_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;

        // Reset state
        check_eq("rst_disp_ready", 64'(disp_ready_out), 64'(1));
        check_eq("rst_valid", 64'(alu_valid_out), 64'(0));
        check_eq("rst_rval1", 64'(alu_rval1_out), 64'(0));
        check_eq("rst_rval2", 64'(alu_rval2_out), 64'(0));
        check_eq("rst_func", 64'(alu_func_out), 64'(0));
        check_eq("rst_rob", 64'(alu_rob_ix_out), 64'(0));

        // 1: ready operands, pulse exactly at D+2
        disp(ALU_ADD, 3'd2, 32'd5, 3'd0, 1'b0, 32'd7, 3'd0, 1'b0);
        tick();
        disp_valid_in = 1'b0;
        check_eq("t1_d1_valid", 64'(alu_valid_out), 64'(0));
        tick();
        check_eq("t1_d2_valid", 64'(alu_valid_out), 64'(1));
        check_eq("t1_func", 64'(alu_func_out), 64'(ALU_ADD));
        check_eq("t1_rval1", 64'(alu_rval1_out), 64'(5));
        check_eq("t1_rval2", 64'(alu_rval2_out), 64'(7));
        check_eq("t1_rob", 64'(alu_rob_ix_out), 64'(2));
        tick();
        check_eq("t1_d3_valid", 64'(alu_valid_out), 64'(0));
        tick();
        tick();

        // 2: operand 1 pending on tag 3, woken two cycles after dispatch
        disp(ALU_SUB, 3'd5, 32'd0, 3'd3, 1'b1, 32'd4, 3'd0, 1'b0);
        tick();
        disp_valid_in = 1'b0;
        cdb(1'b1, 3'd2, 32'd99);          // wrong tag, must not wake
        check_eq("t2_d1_valid", 64'(alu_valid_out), 64'(0));
        tick();
        cdb(1'b1, 3'd3, 32'd10);
        check_eq("t2_d2_valid", 64'(alu_valid_out), 64'(0));
        tick();
        cdb(1'b0, 3'd0, 32'd0);
        check_eq("t2_d3_valid", 64'(alu_valid_out), 64'(0));
        tick();
        check_eq("t2_d4_valid", 64'(alu_valid_out), 64'(1));
        check_eq("t2_rval1", 64'(alu_rval1_out), 64'(10));
        check_eq("t2_rval2", 64'(alu_rval2_out), 64'(4));
        check_eq("t2_func", 64'(alu_func_out), 64'(ALU_SUB));
        check_eq("t2_rob", 64'(alu_rob_ix_out), 64'(5));
        tick();
        check_eq("t2_d5_valid", 64'(alu_valid_out), 64'(0));
        tick();
        tick();

        // 3: CDB bypass at dispatch, no stall
        disp(ALU_AND, 3'd6, 32'd3, 3'd0, 1'b0, 32'd0, 3'd1, 1'b1);
        cdb(1'b1, 3'd1, 32'd9);
        tick();
        disp_valid_in = 1'b0;
        cdb(1'b0, 3'd0, 32'd0);
        check_eq("t3_d1_valid", 64'(alu_valid_out), 64'(0));
        tick();
        check_eq("t3_d2_valid", 64'(alu_valid_out), 64'(1));
        check_eq("t3_rval1", 64'(alu_rval1_out), 64'(3));
        check_eq("t3_rval2", 64'(alu_rval2_out), 64'(9));
        check_eq("t3_rob", 64'(alu_rob_ix_out), 64'(6));
        tick();
        tick();
        tick();

        // 4: fill the station with the ALU not ready, overflow dropped, in-order drain
        alu_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("t4_ready_fill", 64'(disp_ready_out), 64'(1));
            disp(ALU_OR, 3'(i), 32'(100 + i), 3'd0, 1'b0, 32'd1, 3'd0, 1'b0);
            tick();
        end
        disp_valid_in = 1'b0;
        check_eq("t4_full_ready", 64'(disp_ready_out), 64'(0));
        disp(ALU_OR, 3'd7, 32'd999, 3'd0, 1'b0, 32'd1, 3'd0, 1'b0);
        tick();
        disp_valid_in = 1'b0;
        check_eq("t4_full_ready2", 64'(disp_ready_out), 64'(0));
        check_eq("t4_no_issue", 64'(alu_valid_out), 64'(0));
        alu_ready_in = 1'b1;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (alu_valid_out) begin
                if (pulses < 4) begin
                    check_eq("t4_order_rob", 64'(alu_rob_ix_out), 64'(pulses));
                    check_eq("t4_order_rval1", 64'(alu_rval1_out), 64'(100 + pulses));
                end
                pulses++;
            end
        end
        check_eq("t4_pulse_count", 64'(pulses), 64'(4));
        check_eq("t4_drained_ready", 64'(disp_ready_out), 64'(1));

        // 5: held operands stay put while the ALU is not ready
        disp(ALU_SLL, 3'd4, 32'h11, 3'd0, 1'b0, 32'h22, 3'd0, 1'b0);
        tick();
        disp_valid_in = 1'b0;
        check_eq("t5_d1_valid", 64'(alu_valid_out), 64'(0));
        tick();
        check_eq("t5_d2_valid", 64'(alu_valid_out), 64'(1));
        alu_ready_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i < 4) begin
                disp(ALU_XOR, 3'(i), 32'(200 + i), 3'd0, 1'b0, 32'd2, 3'd0, 1'b0);
            end else begin
                disp_valid_in = 1'b0;
            end
            cdb(1'b1, 3'(i), 32'hdead0000 + 32'(i));
            check_eq("t5_hold_valid", 64'(alu_valid_out), 64'(0));
            check_eq("t5_hold_rval1", 64'(alu_rval1_out), 64'h11);
            check_eq("t5_hold_rval2", 64'(alu_rval2_out), 64'h22);
            check_eq("t5_hold_func", 64'(alu_func_out), 64'(ALU_SLL));
            check_eq("t5_hold_rob", 64'(alu_rob_ix_out), 64'(4));
        end
        tick();
        disp_valid_in = 1'b0;
        cdb(1'b0, 3'd0, 32'd0);
        alu_ready_in = 1'b1;
        check_eq("t5_pre_release", 64'(alu_valid_out), 64'(0));
        tick();
        check_eq("t5_idle_valid", 64'(alu_valid_out), 64'(0));
        tick();
        check_eq("t5_next_valid", 64'(alu_valid_out), 64'(1));
        check_eq("t5_next_rob", 64'(alu_rob_ix_out), 64'(0));
        check_eq("t5_next_rval1", 64'(alu_rval1_out), 64'(200));
        check_eq("t5_next_func", 64'(alu_func_out), 64'(ALU_XOR));
        alu_ready_in = 1'b0;

        // 6: flush while BUSY with three entries still valid
        tick();
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        check_eq("t6_disp_ready", 64'(disp_ready_out), 64'(1));
        check_eq("t6_valid", 64'(alu_valid_out), 64'(0));
        check_eq("t6_rval1", 64'(alu_rval1_out), 64'(0));
        check_eq("t6_rob", 64'(alu_rob_ix_out), 64'(0));
        check_eq("t6_func", 64'(alu_func_out), 64'(0));
        alu_ready_in = 1'b1;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (alu_valid_out) begin
                pulses++;
            end
        end
        check_eq("t6_no_stale_issue", 64'(pulses), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
